// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory access sizes, MEM-stage FSM
// encoding and the EX/MEM pipeline bundle.
package mips_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic {
        MEM_RUN  = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        reg_wr;
        logic [4:0]  reg_addr;
        logic [31:0] alu_res;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  mem_size;
        logic        mem_signed;
        logic [31:0] store_data;
    } ex_mem_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte/half/word lane logic: store steering, load extraction
// with sign/zero extension, and alignment checking.
module mem_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rdata[{addr_lo, 3'b000} +: 8];
        half_lane  = rdata[{addr_lo[1], 4'b0000} +: 16];
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{load_signed & byte_lane[7]}}, byte_lane};
            end
            MEM_SIZE_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{load_signed & half_lane[15]}}, half_lane};
                misaligned = addr_lo[0];
            end
            // size 2'b11 is handled exactly like a word access
            MEM_SIZE_WORD, 2'b11: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, data-memory
// req/ack handshake and WB presentation. Define MEM_ACK_TIMEOUT_EN to abort accesses with no ack.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_regWr,
    input  logic [4:0]  ex_regAddr,
    input  logic [31:0] ex_aluRes,
    input  logic        ex_memRd,
    input  logic        ex_memWr,
    input  logic [1:0]  ex_memSize,
    input  logic        ex_memSigned,
    input  logic [31:0] ex_storeData,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        regWr,
    output logic [4:0]  regAddr,
    output logic [31:0] regData,
    output logic        addrErr,
    output logic        busErr
);

    if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
        $error("mem_stage: ACK_TIMEOUT must be at least 1");
    end

    ex_mem_t    s_q, s_d;
    logic       s_valid_q, s_valid_d;
    mem_state_e state_q, state_d;

    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic        memop;
    logic        aligned_op;
    logic        is_load;
    logic        complete;
    logic        timeout;

    mem_align u_align (
        .size        (s_q.mem_size),
        .addr_lo     (s_q.alu_res[1:0]),
        .load_signed (s_q.mem_signed),
        .store_data  (s_q.store_data),
        .rdata       (dm_rdata),
        .be          (be),
        .wdata       (wdata),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    assign memop      = s_valid_q & (s_q.mem_rd | s_q.mem_wr);
    assign aligned_op = memop & ~misaligned;
    assign is_load    = ~s_q.mem_wr;
    assign complete   = aligned_op & dm_ack;

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts completed WAIT cycles; the last permitted one is the abort cycle.
    assign timeout = (state_q == MEM_WAIT) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == MEM_WAIT && !dm_ack && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busErr = timeout & ~dm_ack;
`else
    assign timeout = 1'b0;
    assign busErr  = 1'b0;
`endif

    // An ack on the timeout cycle still completes the access normally.
    assign stall = aligned_op & ~dm_ack & ~timeout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_RUN:  if (aligned_op && !dm_ack) state_d = MEM_WAIT;
            MEM_WAIT: if (dm_ack || timeout)     state_d = MEM_RUN;
        endcase
    end

    always_comb begin
        s_d       = s_q;
        s_valid_d = s_valid_q;
        if (!stall) begin
            s_valid_d      = ex_valid;
            s_d.reg_wr     = ex_regWr;
            s_d.reg_addr   = ex_regAddr;
            s_d.alu_res    = ex_aluRes;
            s_d.mem_rd     = ex_memRd;
            s_d.mem_wr     = ex_memWr;
            s_d.mem_size   = ex_memSize;
            s_d.mem_signed = ex_memSigned;
            s_d.store_data = ex_storeData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid_q <= 1'b0;
            state_q   <= MEM_RUN;
        end else begin
            s_valid_q <= s_valid_d;
            state_q   <= state_d;
        end
    end

    // Payload needs no reset: every consumer is qualified by s_valid_q.
    always_ff @(posedge clk) begin
        s_q <= s_d;
    end

    assign dm_req   = aligned_op;
    assign dm_we    = aligned_op & s_q.mem_wr;
    assign dm_addr  = aligned_op ? {s_q.alu_res[31:2], 2'b00} : 32'h0;
    assign dm_be    = aligned_op ? be : 4'b0000;
    assign dm_wdata = dm_we ? wdata : 32'h0;

    assign regWr   = s_valid_q & s_q.reg_wr & (~memop | (complete & is_load));
    assign regAddr = s_valid_q ? s_q.reg_addr : 5'd0;
    assign regData = (s_valid_q & ~memop)  ? s_q.alu_res :
                     (complete & is_load)  ? load_data   : 32'h0;
    assign addrErr = memop & misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: instruction-level model of the MEM stage
// checked every cycle, plus hand-computed literal expectations.
module tb_mem_stage;

    localparam int TO = 16;
`ifdef MEM_ACK_TIMEOUT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_regWr, ex_memRd, ex_memWr, ex_memSigned;
    logic [4:0]  ex_regAddr;
    logic [31:0] ex_aluRes, ex_storeData;
    logic [1:0]  ex_memSize;
    logic        stall, dm_req, dm_we, dm_ack, regWr, addrErr, busErr;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, regData;
    logic [3:0]  dm_be;
    logic [4:0]  regAddr;

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_regWr(ex_regWr),
        .ex_regAddr(ex_regAddr), .ex_aluRes(ex_aluRes), .ex_memRd(ex_memRd),
        .ex_memWr(ex_memWr), .ex_memSize(ex_memSize), .ex_memSigned(ex_memSigned),
        .ex_storeData(ex_storeData), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ack(dm_ack), .regWr(regWr), .regAddr(regAddr), .regData(regData),
        .addrErr(addrErr), .busErr(busErr)
    );

    always #5 clk = ~clk;

    // kind: 0 ALU, 1 load, 2 store
    typedef struct {
        int          kind;
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
        logic        lit;
        logic [3:0]  lbe;
        logic [31:0] lval;
        int          lstall;
    } vec_t;

    vec_t vecs[$];
    int   stream[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int kind, input logic rw, input logic [4:0] ra,
                       input logic [31:0] addr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] sd, input logic [31:0] rd, input int dly,
                       input int gap, input logic lit, input logic [3:0] lbe,
                       input logic [31:0] lval, input int lstall);
        vec_t v;
        v.kind = kind; v.rw = rw; v.ra = ra; v.addr = addr; v.sz = sz; v.sgn = sgn;
        v.sd = sd; v.rd = rd; v.dly = dly; v.lit = lit; v.lbe = lbe; v.lval = lval;
        v.lstall = lstall;
        vecs.push_back(v);
        repeat (gap) stream.push_back(-1);
        stream.push_back(int'(vecs.size()) - 1);
    endtask

    function automatic bit is_mis(vec_t v);
        if (v.sz == 2'd1) return v.addr[0];
        if (v.sz >= 2'd2) return v.addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(vec_t v);
        if (v.sz == 2'd0) return 4'b0001 << v.addr[1:0];
        if (v.sz == 2'd1) return v.addr[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wd(vec_t v);
        if (v.sz == 2'd0) return {4{v.sd[7:0]}};
        if (v.sz == 2'd1) return {2{v.sd[15:0]}};
        return v.sd;
    endfunction

    function automatic logic [31:0] exp_load(vec_t v);
        logic [31:0] w;
        if (v.sz == 2'd0) begin
            w = (v.rd >> (8 * v.addr[1:0])) & 32'hFF;
            if (v.sgn && w >= 32'h80) w = w | 32'hFFFF_FF00;
            return w;
        end
        if (v.sz == 2'd1) begin
            w = (v.rd >> (16 * v.addr[1])) & 32'hFFFF;
            if (v.sgn && w >= 32'h8000) w = w | 32'hFFFF_0000;
            return w;
        end
        return v.rd;
    endfunction

    task automatic drive_ex(input int idx);
        vec_t v;
        if (idx < 0) begin
            ex_valid = 1'b0; ex_regWr = 1'b1; ex_regAddr = 5'd31; ex_aluRes = 32'hFFFF_FFFC;
            ex_memRd = 1'b1; ex_memWr = 1'b0; ex_memSize = 2'd2; ex_memSigned = 1'b1;
            ex_storeData = 32'h5A5A_5A5A;
        end else begin
            v = vecs[idx];
            ex_valid = 1'b1; ex_regWr = v.rw; ex_regAddr = v.ra; ex_aluRes = v.addr;
            ex_memRd = (v.kind == 1); ex_memWr = (v.kind == 2); ex_memSize = v.sz;
            ex_memSigned = v.sgn; ex_storeData = v.sd;
        end
    endtask

    // Expected outputs for the instruction in MEM, kk cycles after it entered.
    task automatic compare(input int idx, input int kk, input bit ack, output bit st);
        vec_t v;
        bit   ab;
        bit   ld;
        st = 1'b0;
        if (idx < 0) begin
            chk("bubble_req", dm_req, 0); chk("bubble_regWr", regWr, 0);
            chk("bubble_stall", stall, 0); chk("bubble_addrErr", addrErr, 0);
            chk("bubble_busErr", busErr, 0);
            return;
        end
        v = vecs[idx];
        if (v.kind == 0) begin
            chk("alu_regWr", regWr, v.rw); chk("alu_regAddr", regAddr, v.ra);
            chk("alu_regData", regData, v.addr); chk("alu_req", dm_req, 0);
            chk("alu_stall", stall, 0); chk("alu_addrErr", addrErr, 0);
            if (v.lit) chk("lit_alu_data", regData, v.lval);
            return;
        end
        if (is_mis(v)) begin
            chk("mis_req", dm_req, 0); chk("mis_regWr", regWr, 0);
            chk("mis_regAddr", regAddr, v.ra); chk("mis_stall", stall, 0);
            chk("mis_addrErr", addrErr, 1); chk("mis_busErr", busErr, 0);
            if (v.lit) chk("lit_addrErr", addrErr, v.lval);
            return;
        end
        ld = (v.kind == 1);
        ab = FEAT && kk == TO && !ack;
        st = !ack && !ab;
        chk("mem_req", dm_req, 1); chk("mem_we", dm_we, !ld);
        chk("mem_addr", dm_addr, {v.addr[31:2], 2'b00}); chk("mem_be", dm_be, exp_be(v));
        if (!ld) chk("mem_wdata", dm_wdata, exp_wd(v));
        chk("mem_stall", stall, st); chk("mem_addrErr", addrErr, 0);
        chk("mem_busErr", busErr, ab); chk("mem_regAddr", regAddr, v.ra);
        if (ack && ld) begin
            chk("load_regWr", regWr, v.rw); chk("load_regData", regData, exp_load(v));
        end else begin
            chk("mem_regWr", regWr, 0);
            if (!ack) chk("wait_regData", regData, 0);
        end
        if (ack && v.lit) begin
            chk("lit_be", dm_be, v.lbe);
            if (ld) chk("lit_load_data", regData, v.lval);
            else    chk("lit_wdata", dm_wdata, v.lval);
        end
    endtask

    initial begin
        int  ex_item, cur, k, sp, stall_seen;
        bit  prev_stall, done, st;

        //   kind rw ra addr          sz sg sd             rd             dly  gap lit lbe   lval           lstall
        add(0, 1, 5,  32'h1234_5678, 0, 0, 32'h0,         32'h0,         0,   0,  1, 4'h0, 32'h1234_5678, 0);
        add(1, 1, 7,  32'h0000_0103, 0, 1, 32'h0,         32'h80FF_0000, 0,   1,  1, 4'h8, 32'hFFFF_FF80, 0);
        add(2, 0, 0,  32'h0000_0202, 1, 0, 32'hAAAA_BEEF, 32'h0,         3,   0,  1, 4'hC, 32'hBEEF_BEEF, 3);
        add(1, 1, 9,  32'h0000_0301, 2, 0, 32'h0,         32'h1111_1111, 0,   0,  1, 4'h0, 32'h1,         0);
        add(1, 1, 3,  32'h0000_0101, 0, 0, 32'h0,         32'h1234_80CD, 1,   0,  1, 4'h2, 32'h0000_0080, 1);
        add(1, 1, 4,  32'h0000_0102, 1, 1, 32'h0,         32'h8001_7FFF, 2,   0,  1, 4'hC, 32'hFFFF_8001, 2);
        add(1, 1, 4,  32'h0000_0100, 1, 0, 32'h0,         32'h8001_F00D, 0,   1,  1, 4'h3, 32'h0000_F00D, 0);
        add(2, 1, 8,  32'h0000_00FE, 0, 0, 32'h1122_33A5, 32'h0,         0,   0,  1, 4'h4, 32'hA5A5_A5A5, 0);
        add(2, 0, 1,  32'h0000_0400, 2, 0, 32'hCAFE_F00D, 32'h0,         1,   0,  1, 4'hF, 32'hCAFE_F00D, 1);
        add(1, 1, 0,  32'h0000_0404, 2, 0, 32'h0,         32'hDEAD_BEEF, 0,   0,  1, 4'hF, 32'hDEAD_BEEF, 0);
        add(2, 0, 2,  32'h0000_0203, 1, 0, 32'h1234_5678, 32'h0,         0,   0,  1, 4'h0, 32'h1,         0);
        add(1, 1, 11, 32'h0000_0408, 3, 0, 32'h0,         32'h0102_0304, 1,   0,  1, 4'hF, 32'h0102_0304, 1);
        add(0, 0, 6,  32'h0000_0055, 0, 0, 32'h0,         32'h0,         0,   0,  1, 4'h0, 32'h0000_0055, 0);
        add(1, 1, 12, 32'h0000_0100, 0, 1, 32'h0,         32'hFFFF_FF7F, 0,   2,  1, 4'h1, 32'h0000_007F, 0);
`ifdef MEM_ACK_TIMEOUT_EN
        add(2, 0, 1,  32'h0000_0600, 2, 0, 32'h7777_0000, 32'h0,         1000, 0, 0, 4'h0, 32'h0,         16);
        add(2, 0, 1,  32'h0000_0604, 2, 0, 32'h7777_0004, 32'h0,         16,  0,  1, 4'hF, 32'h7777_0004, 16);
`else
        add(1, 1, 14, 32'h0000_0600, 2, 0, 32'h0,         32'h600D_F00D, 20,  0,  1, 4'hF, 32'h600D_F00D, 20);
`endif
        add(0, 1, 15, 32'h0BAD_CAFE, 0, 0, 32'h0,         32'h0,         0,   0,  0, 4'h0, 32'h0,         0);
        repeat (3) stream.push_back(-1);

        // Reset state: outputs low while rst is asserted.
        rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        drive_ex(0);
        #3;
        chk("rst_req", dm_req, 0); chk("rst_stall", stall, 0); chk("rst_regWr", regWr, 0);
        chk("rst_regAddr", regAddr, 0); chk("rst_regData", regData, 0);
        chk("rst_addrErr", addrErr, 0); chk("rst_busErr", busErr, 0);
        chk("rst_be", dm_be, 0); chk("rst_addr", dm_addr, 0);

        @(negedge clk);
        rst = 1'b1;
        sp = 0; ex_item = stream[0]; drive_ex(ex_item);
        cur = -1; k = 0; stall_seen = 0; prev_stall = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (!prev_stall) begin
                if (cur >= 0 && vecs[cur].lstall >= 0)
                    chk("lit_stall_cycles", stall_seen, vecs[cur].lstall);
                cur = ex_item; k = 0; stall_seen = 0;
                sp++;
                ex_item = (sp < stream.size()) ? stream[sp] : -1;
                drive_ex(ex_item);
                if (cur < 0 && ex_item < 0) done = 1'b1;
            end else begin
                k++;
            end
            if (cur >= 0 && vecs[cur].kind != 0 && !is_mis(vecs[cur])) begin
                dm_ack   = (k == vecs[cur].dly);
                dm_rdata = dm_ack ? vecs[cur].rd : 32'hDEAD_BEEF;
            end else begin
                dm_ack   = 1'b1;
                dm_rdata = 32'h0BAD_0BAD;
            end
            #1;
            compare(cur, k, dm_ack, st);
            if (stall) stall_seen++;
            prev_stall = st;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL stream_budget got=unfinished want=finished");
        end

        // Reset asserted while an access waits for its ack.
        @(negedge clk);
        dm_ack = 1'b0; dm_rdata = 32'h0;
        ex_valid = 1'b1; ex_regWr = 1'b1; ex_regAddr = 5'd12; ex_aluRes = 32'h0000_0500;
        ex_memRd = 1'b1; ex_memWr = 1'b0; ex_memSize = 2'd2; ex_memSigned = 1'b0;
        @(negedge clk); #1;
        chk("rw_req_run", dm_req, 1); chk("rw_stall_run", stall, 1);
        @(negedge clk); #1;
        chk("rw_req_wait", dm_req, 1); chk("rw_stall_wait", stall, 1);
        #2 rst = 1'b0;
        #1;
        chk("rw_req_rst", dm_req, 0); chk("rw_stall_rst", stall, 0);
        chk("rw_regWr_rst", regWr, 0); chk("rw_addr_rst", dm_addr, 0);
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dm_ack = 1'b1; dm_rdata = 32'h1357_2468;
        #1;
        chk("rw_req_post", dm_req, 0); chk("rw_regWr_post", regWr, 0);
        chk("rw_stall_post", stall, 0);
        ex_valid = 1'b1; ex_regAddr = 5'd13; ex_aluRes = 32'h0000_0504;
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("rw_req_new", dm_req, 1); chk("rw_stall_new", stall, 0);
        chk("rw_regWr_new", regWr, 1); chk("rw_regAddr_new", regAddr, 13);
        chk("rw_regData_new", regData, 32'h1357_2468);
        @(negedge clk); #1;
        chk("rw_regWr_after", regWr, 0); chk("rw_req_after", dm_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, between EX and WB.
- Holds the EX/MEM pipeline register and drives the data-memory request/ack interface.
- Does byte/half/word store lane steering and load extraction with sign or zero extension.
- Presents regWr/regAddr/regData to WB for exactly one cycle per retired instruction, and stalls upstream while a memory access is pending.

Parameters:
- ACK_TIMEOUT, 16, cycles to wait for dm_ack before aborting. Used only with MEM_ACK_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX presents an instruction.
- ex_regWr  in  1  instruction writes the register file.
- ex_regAddr  in  5  destination register.
- ex_aluRes  in  32  ALU result, or effective address for loads/stores.
- ex_memRd  in  1  load.
- ex_memWr  in  1  store.
- ex_memSize  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- ex_memSigned  in  1  sign-extend the load result.
- ex_storeData  in  32  store source register value.
- stall  out  1  upstream must hold EX outputs.
- dm_req  out  1  memory request.
- dm_we  out  1  write request.
- dm_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  read data, valid when dm_ack=1.
- dm_ack  in  1  access complete this cycle.
- regWr  out  1  to WB.
- regAddr  out  5  to WB.
- regData  out  32  to WB.
- addrErr  out  1  one-cycle pulse on a misaligned access.
- busErr  out  1  one-cycle pulse on timeout abort; constant 0 without the optional feature.

Behaviour:
- Stage register S (valid + all ex_* fields) loads on posedge when stall=0. If ex_valid=0, S.valid becomes 0 (bubble).
- Reset clears S.valid, sets FSM=RUN, clears the timeout counter. All outputs go to 0 immediately, including a pending dm_req.
- memop = S.valid & (memRd|memWr).
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- Misaligned memop:
  - no dm_req issued;
  - regWr=0;
  - addrErr=1 for that one cycle;
  - completes in 1 cycle.
- FSM states RUN and WAIT:
  - RUN, aligned memop: dm_req=1. If dm_ack=1, complete this cycle. Otherwise go to WAIT.
  - WAIT: dm_req held with stable addr/be/wdata. On dm_ack=1, complete and return to RUN.
- stall = aligned memop & ~dm_ack (combinational).
- Non-mem instruction: regWr=S.regWr, regData=S.aluRes in the cycle after acceptance. Total latency from EX to WB sample is 2 edges.
- Completion outputs:
  - Load completion: regWr=S.regWr, regData = extracted value.
  - Store completion: regWr=0.
  - While waiting: regWr=0, regAddr=S.regAddr, regData=0.
- Store steering:
  - byte: be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}};
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{sd[15:0]}};
  - word: be=4'b1111, wdata=sd.
- Load extraction:
  - byte lane = rdata[8*addr[1:0]+:8];
  - half lane = rdata[16*addr[1]+:16];
  - extend by memSigned.
- Loads use dm_be with the same enables; dm_we=0.
- Writes to regAddr 0 pass through unchanged; the register file ignores them.
- dm_ack while dm_req=0 is ignored.
- Only one outstanding request; no new request is issued in the ack cycle of the previous one.

Optional Feature:
- MEM_ACK_TIMEOUT_EN defined:
  - a counter runs while in WAIT;
  - if ACK_TIMEOUT cycles elapse with no ack, the access aborts: dm_req drops, busErr pulses 1 cycle, regWr=0, FSM returns to RUN, stall releases;
  - an ack arriving on the same cycle as the timeout wins (normal completion).
- MEM_ACK_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; busErr tied to 0.

Decomposition:
- Shared package mips_pkg: MEM_SIZE_BYTE/HALF/WORD constants, MEM FSM state encoding, ex_mem bundle typedef.
- One sub-module, mem_align: purely combinational store steering and load extraction, reusable by a future cache.

Test Plan:
- ALU op, aluRes=0x1234_5678, regAddr=5 → two edges later WB sees regWr=1, regAddr=5, regData=0x1234_5678 for exactly one cycle; dm_req never asserts.
- lb, addr=0x103, ack same cycle, rdata=0x80FF_0000, signed → dm_addr=0x100, dm_be=1000, regData=0xFFFF_FF80, stall=0.
- sh, addr=0x202, sd=0xAAAA_BEEF, ack after 3 cycles → dm_be=1100, dm_wdata=0xBEEF_BEEF, dm_we=1, stall=1 for 3 cycles, then regWr=0 and the next instruction is accepted.
- lw, addr=0x301 → no dm_req, addrErr single pulse, regWr=0, no stall.
- Reset asserted mid-WAIT → dm_req, stall, regWr drop immediately. After release, FSM=RUN and S.valid=0.
- MEM_ACK_TIMEOUT_EN, ACK_TIMEOUT=16, ack never arrives → busErr pulses after 16 cycles of WAIT and stall releases. Repeat with ack on cycle 16 → normal completion, busErr=0.
